// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the IF/LS Wishbone arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQUEST, ARB_WAIT_ACK} mem_arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = WB_DW / 8;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipelined Wishbone B4 bundle; names are seen from the arbiter (master) side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [WB_AW-1:0] wb_adr_o;
  logic [WB_DW-1:0] wb_dat_o;
  logic             wb_we_o;
  logic [WB_SW-1:0] wb_sel_o;
  logic             wb_stb_o;
  logic             wb_cyc_o;
  logic [WB_DW-1:0] wb_dat_i;
  logic             wb_ack_i;
  logic             wb_stall_i;
  logic             wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_stall_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_stall_i, wb_err_i
  );

endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (LS over IF) arbiter for one Wishbone master port; registered outputs, stb held while stalled.
// Define MEM_ARB_TIMEOUT_EN to abort a bus cycle with err after TIMEOUT_CYCLES without a response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             if_req_i,
  input  logic [WB_AW-1:0] if_addr_i,
  output logic             if_ack_o,
  output logic             if_err_o,
  output logic [WB_DW-1:0] if_data_o,
  input  logic             ls_req_i,
  input  logic             ls_we_i,
  input  logic [WB_SW-1:0] ls_sel_i,
  input  logic [WB_AW-1:0] ls_addr_i,
  input  logic [WB_DW-1:0] ls_data_i,
  output logic             ls_ack_o,
  output logic             ls_err_o,
  output logic [WB_DW-1:0] ls_data_o,
  mem_arbiter_if.master    wb
);

  mem_arb_state_t   r_state, w_state_nxt;
  logic             r_owner, w_owner_nxt;
  logic [WB_AW-1:0] r_adr, w_adr_nxt;
  logic [WB_DW-1:0] r_dat, w_dat_nxt;
  logic             r_we, w_we_nxt;
  logic [WB_SW-1:0] r_sel, w_sel_nxt;
  logic             r_stb, w_stb_nxt;
  logic             r_cyc, w_cyc_nxt;
  logic             r_if_ack, w_if_ack_nxt, r_if_err, w_if_err_nxt;
  logic             r_ls_ack, w_ls_ack_nxt, r_ls_err, w_ls_err_nxt;
  logic [WB_DW-1:0] r_if_data, w_if_data_nxt, r_ls_data, w_ls_data_nxt;
  logic             w_if_req, w_ls_req, w_bus_resp, w_timeout, w_done, w_done_err;

  // A requester whose completion pulse is high right now may not have dropped req yet.
  assign w_if_req   = if_req_i & ~(r_if_ack | r_if_err);
  assign w_ls_req   = ls_req_i & ~(r_ls_ack | r_ls_err);
  assign w_bus_resp = (((r_state == ARB_REQUEST) && !wb.wb_stall_i) || (r_state == ARB_WAIT_ACK))
                      && (wb.wb_ack_i || wb.wb_err_i);
  assign w_done     = w_bus_resp || w_timeout;
  assign w_done_err = (w_bus_resp && wb.wb_err_i) || w_timeout;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_busy;

  assign w_busy    = (r_state == ARB_REQUEST) || (r_state == ARB_WAIT_ACK);
  assign w_timeout = w_busy && !w_bus_resp && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == ARB_IDLE) begin
      if (w_if_req || w_ls_req) w_cnt_nxt = '0;
    end else if (w_busy && !w_done) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_cnt <= '0;
    else         r_cnt <= w_cnt_nxt;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_adr_nxt     = r_adr;
    w_dat_nxt     = r_dat;
    w_we_nxt      = r_we;
    w_sel_nxt     = r_sel;
    w_stb_nxt     = r_stb;
    w_cyc_nxt     = r_cyc;
    w_if_ack_nxt  = 1'b0;
    w_if_err_nxt  = 1'b0;
    w_ls_ack_nxt  = 1'b0;
    w_ls_err_nxt  = 1'b0;
    w_if_data_nxt = '0;
    w_ls_data_nxt = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_ls_req || w_if_req) begin
          w_state_nxt = ARB_REQUEST;
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = 1'b1;
          if (w_ls_req) begin
            w_owner_nxt = OWNER_LS;
            w_adr_nxt   = ls_addr_i;
            w_dat_nxt   = ls_data_i;
            w_we_nxt    = ls_we_i;
            w_sel_nxt   = ls_sel_i;
          end else begin
            w_owner_nxt = OWNER_IF;
            w_adr_nxt   = if_addr_i;
            w_dat_nxt   = '0;
            w_we_nxt    = 1'b0;
            w_sel_nxt   = '1;
          end
        end
      end
      ARB_REQUEST, ARB_WAIT_ACK: begin
        if (w_done) begin
          w_state_nxt = ARB_IDLE;
          w_cyc_nxt   = 1'b0;
          w_stb_nxt   = 1'b0;
          if (r_owner == OWNER_IF) begin
            w_if_err_nxt = w_done_err;
            w_if_ack_nxt = !w_done_err;
            if (!w_done_err) w_if_data_nxt = wb.wb_dat_i;
          end else begin
            w_ls_err_nxt = w_done_err;
            w_ls_ack_nxt = !w_done_err;
            if (!w_done_err && !r_we) w_ls_data_nxt = wb.wb_dat_i;
          end
        end else if ((r_state == ARB_REQUEST) && !wb.wb_stall_i) begin
          w_stb_nxt   = 1'b0;
          w_state_nxt = ARB_WAIT_ACK;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_cyc_nxt   = 1'b0;
        w_stb_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWNER_IF;
      r_adr     <= '0;
      r_dat     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_stb     <= 1'b0;
      r_cyc     <= 1'b0;
      r_if_ack  <= 1'b0;
      r_if_err  <= 1'b0;
      r_ls_ack  <= 1'b0;
      r_ls_err  <= 1'b0;
      r_if_data <= '0;
      r_ls_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_adr     <= w_adr_nxt;
      r_dat     <= w_dat_nxt;
      r_we      <= w_we_nxt;
      r_sel     <= w_sel_nxt;
      r_stb     <= w_stb_nxt;
      r_cyc     <= w_cyc_nxt;
      r_if_ack  <= w_if_ack_nxt;
      r_if_err  <= w_if_err_nxt;
      r_ls_ack  <= w_ls_ack_nxt;
      r_ls_err  <= w_ls_err_nxt;
      r_if_data <= w_if_data_nxt;
      r_ls_data <= w_ls_data_nxt;
    end
  end

  assign wb.wb_adr_o = r_adr;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_we_o  = r_we;
  assign wb.wb_sel_o = r_sel;
  assign wb.wb_stb_o = r_stb;
  assign wb.wb_cyc_o = r_cyc;
  assign if_ack_o    = r_if_ack;
  assign if_err_o    = r_if_err;
  assign if_data_o   = r_if_data;
  assign ls_ack_o    = r_ls_ack;
  assign ls_err_o    = r_ls_err;
  assign ls_data_o   = r_ls_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Per-cycle vector table for mem_arbiter plus a long no-response sequence for the timeout option.
module tb_mem_arbiter;

  localparam int unsigned TB_TIMEOUT = 8;
  localparam logic        H = 1'b1;
  localparam logic        L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  typedef struct packed {
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_sel;
    logic [31:0] ls_addr;
    logic [31:0] ls_data;
    logic [31:0] dat_i;
    logic        ack;
    logic        stall;
    logic        err;
  } vin_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        if_ack;
    logic        if_err;
    logic [31:0] if_data;
    logic        ls_ack;
    logic        ls_err;
    logic [31:0] ls_data;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o, if_err_o;
  logic [31:0] if_data_o;
  logic        ls_req_i, ls_we_i;
  logic [3:0]  ls_sel_i;
  logic [31:0] ls_addr_i, ls_data_i;
  logic        ls_ack_o, ls_err_o;
  logic [31:0] ls_data_o;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  mem_arbiter_if wb_if();

  mem_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .if_req_i  (if_req_i),
    .if_addr_i (if_addr_i),
    .if_ack_o  (if_ack_o),
    .if_err_o  (if_err_o),
    .if_data_o (if_data_o),
    .ls_req_i  (ls_req_i),
    .ls_we_i   (ls_we_i),
    .ls_sel_i  (ls_sel_i),
    .ls_addr_i (ls_addr_i),
    .ls_data_i (ls_data_i),
    .ls_ack_o  (ls_ack_o),
    .ls_err_o  (ls_err_o),
    .ls_data_o (ls_data_o),
    .wb        (wb_if)
  );

  always #5 clk_i = ~clk_i;

  function automatic vin_t mk_in(logic rst, logic ifr, logic [31:0] ifa, logic lsr, logic we,
                                 logic [3:0] sel, logic [31:0] lsa, logic [31:0] lsd,
                                 logic [31:0] dat, logic ack, logic stall, logic err);
    return '{rst, ifr, ifa, lsr, we, sel, lsa, lsd, dat, ack, stall, err};
  endfunction

  function automatic vout_t mk_out(logic cyc, logic stb, logic [31:0] adr, logic we, logic [3:0] sel,
                                   logic [31:0] dat, logic ifack, logic iferr, logic [31:0] ifdat,
                                   logic lsack, logic lserr, logic [31:0] lsdat);
    return '{cyc, stb, adr, we, sel, dat, ifack, iferr, ifdat, lsack, lserr, lsdat};
  endfunction

  // Address/data/we/sel are don't-care while cyc is low.
  function automatic vout_t mask(input vout_t v, input logic bus_live);
    vout_t m;
    m = v;
    if (!bus_live) begin
      m.adr = '0;
      m.we  = 1'b0;
      m.sel = '0;
      m.dat = '0;
    end
    return m;
  endfunction

  function automatic vout_t cap();
    return '{wb_if.wb_cyc_o, wb_if.wb_stb_o, wb_if.wb_adr_o, wb_if.wb_we_o, wb_if.wb_sel_o,
             wb_if.wb_dat_o, if_ack_o, if_err_o, if_data_o, ls_ack_o, ls_err_o, ls_data_o};
  endfunction

  task automatic drive(input vin_t v);
    rst_ni           = v.rst_n;
    if_req_i         = v.if_req;
    if_addr_i        = v.if_addr;
    ls_req_i         = v.ls_req;
    ls_we_i          = v.ls_we;
    ls_sel_i         = v.ls_sel;
    ls_addr_i        = v.ls_addr;
    ls_data_i        = v.ls_data;
    wb_if.wb_dat_i   = v.dat_i;
    wb_if.wb_ack_i   = v.ack;
    wb_if.wb_stall_i = v.stall;
    wb_if.wb_err_i   = v.err;
  endtask

  task automatic add(input vin_t i, input vout_t o);
    vecs.push_back('{i, o});
  endtask

  task automatic check_vec(input int idx, input vout_t exp);
    vout_t act, req;
    act = mask(cap(), exp.cyc);
    req = mask(exp, exp.cyc);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL vec%0d: got %h required %h", idx, act, req);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  initial begin
    vin_t  i_idle;
    vout_t o_idle;
    int    cyc_cnt;
    int    err_cnt;
    logic  cyc_at_err;

    i_idle = mk_in(H, L, Z, L, L, 4'h0, Z, Z, Z, L, L, L);
    o_idle = mk_out(L, L, Z, L, 4'h0, Z, L, L, Z, L, L, Z);

    // reset, including with every input active
    add(mk_in(L, L, Z, L, L, 4'h0, Z, Z, Z, L, L, L), o_idle);
    add(mk_in(L, H, 32'h100, H, H, 4'hF, 32'h200, 32'h55, 32'h77, H, L, H), o_idle);
    // IF read, ack one cycle after stb, req dropped one cycle late
    add(mk_in(H, H, 32'h100, L, L, 4'h0, Z, Z, Z, L, L, L), mk_out(H, H, 32'h100, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, H, 32'h100, L, L, 4'h0, Z, Z, Z, L, L, L), mk_out(H, L, 32'h100, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, H, 32'h100, L, L, 4'h0, Z, Z, 32'hDEADBEEF, H, L, L), mk_out(L, L, Z, L, 4'h0, Z, H, L, 32'hDEADBEEF, L, L, Z));
    add(mk_in(H, H, 32'h100, L, L, 4'h0, Z, Z, Z, L, L, L), o_idle);
    add(i_idle, o_idle);
    // simultaneous requests: LS store first, IF after one idle cycle
    add(mk_in(H, H, 32'h300, H, H, 4'h3, 32'h200, 32'h1234, Z, L, L, L), mk_out(H, H, 32'h200, H, 4'h3, 32'h1234, L, L, Z, L, L, Z));
    add(mk_in(H, H, 32'h300, H, H, 4'h3, 32'h200, 32'h1234, Z, L, L, L), mk_out(H, L, 32'h200, H, 4'h3, 32'h1234, L, L, Z, L, L, Z));
    add(mk_in(H, H, 32'h300, H, H, 4'h3, 32'h200, 32'h1234, 32'hCAFEF00D, H, L, L), mk_out(L, L, Z, L, 4'h0, Z, L, L, Z, H, L, Z));
    add(mk_in(H, H, 32'h300, H, H, 4'h3, 32'h200, 32'h1234, Z, L, L, L), mk_out(H, H, 32'h300, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, H, 32'h300, L, L, 4'h0, Z, Z, Z, L, L, L), mk_out(H, L, 32'h300, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, H, 32'h300, L, L, 4'h0, Z, Z, 32'h11112222, H, L, L), mk_out(L, L, Z, L, 4'h0, Z, H, L, 32'h11112222, L, L, Z));
    add(i_idle, o_idle);
    // LS load, stalled three cycles (ack during stall ignored), ack two cycles after acceptance
    add(mk_in(H, L, Z, H, L, 4'hF, 32'h40, Z, Z, L, L, L), mk_out(H, H, 32'h40, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, L, Z, H, L, 4'hF, 32'h40, Z, Z, L, H, L), mk_out(H, H, 32'h40, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, L, Z, H, L, 4'hF, 32'h40, Z, 32'h99999999, H, H, L), mk_out(H, H, 32'h40, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, L, Z, H, L, 4'hF, 32'h40, Z, Z, L, H, L), mk_out(H, H, 32'h40, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, L, Z, H, L, 4'hF, 32'h40, Z, Z, L, L, L), mk_out(H, L, 32'h40, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, L, Z, H, L, 4'hF, 32'h40, Z, Z, L, L, L), mk_out(H, L, 32'h40, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, L, Z, H, L, 4'hF, 32'h40, Z, 32'h5A5A0001, H, L, L), mk_out(L, L, Z, L, 4'h0, Z, L, L, Z, H, L, 32'h5A5A0001));
    add(i_idle, o_idle);
    add(mk_in(H, L, Z, L, L, 4'h0, Z, Z, 32'h87654321, H, L, H), o_idle);
    // ack+err on IF read in REQUEST: err wins; LS granted while IF err pulses; LS ack in REQUEST
    add(mk_in(H, H, 32'h104, L, L, 4'h0, Z, Z, Z, L, L, L), mk_out(H, H, 32'h104, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, H, 32'h104, L, L, 4'h0, Z, Z, 32'hFFFFFFFF, H, L, H), mk_out(L, L, Z, L, 4'h0, Z, L, H, Z, L, L, Z));
    add(mk_in(H, H, 32'h104, H, L, 4'hF, 32'h80, 32'hAAAA5555, Z, L, L, L), mk_out(H, H, 32'h80, L, 4'hF, 32'hAAAA5555, L, L, Z, L, L, Z));
    add(mk_in(H, H, 32'h104, H, L, 4'hF, 32'h80, 32'hAAAA5555, 32'h0BADF00D, H, L, L), mk_out(L, L, Z, L, 4'h0, Z, L, L, Z, H, L, 32'h0BADF00D));
    add(mk_in(H, L, Z, H, L, 4'hF, 32'h80, 32'hAAAA5555, Z, L, L, L), o_idle);
    add(i_idle, o_idle);
    // reset during WAIT_ACK, then a late ack, then a normal store
    add(mk_in(H, H, 32'h108, L, L, 4'h0, Z, Z, Z, L, L, L), mk_out(H, H, 32'h108, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(H, H, 32'h108, L, L, 4'h0, Z, Z, Z, L, L, L), mk_out(H, L, 32'h108, L, 4'hF, Z, L, L, Z, L, L, Z));
    add(mk_in(L, H, 32'h108, L, L, 4'h0, Z, Z, Z, L, L, L), o_idle);
    add(mk_in(H, L, Z, L, L, 4'h0, Z, Z, 32'h12345678, H, L, L), o_idle);
    add(mk_in(H, L, Z, H, H, 4'hC, 32'h44, 32'h0F0F0000, Z, L, L, L), mk_out(H, H, 32'h44, H, 4'hC, 32'h0F0F0000, L, L, Z, L, L, Z));
    add(mk_in(H, L, Z, H, H, 4'hC, 32'h44, 32'h0F0F0000, 32'h13579BDF, H, L, L), mk_out(L, L, Z, L, 4'h0, Z, L, L, Z, H, L, Z));
    add(i_idle, o_idle);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].i);
      @(posedge clk_i);
      #1;
      check_vec(k, vecs[k].o);
    end

    // LS store that never gets a response
    cyc_cnt    = 0;
    err_cnt    = 0;
    cyc_at_err = 1'b1;
    drive(mk_in(H, L, Z, H, H, 4'hF, 32'h500, 32'hAB, Z, L, L, L));
    for (int t = 0; t < 100; t++) begin
      @(posedge clk_i);
      #1;
      if (wb_if.wb_cyc_o) cyc_cnt++;
      if (ls_err_o) begin
        err_cnt++;
        cyc_at_err = wb_if.wb_cyc_o;
        ls_req_i   = 1'b0;
      end
    end
`ifdef MEM_ARB_TIMEOUT_EN
    chk("timeout_err_pulses", 32'(err_cnt), 32'd1);
    chk("timeout_cyc_cycles", 32'(cyc_cnt), 32'(TB_TIMEOUT + 1));
    chk("timeout_cyc_at_err", {31'd0, cyc_at_err}, 32'd0);
`else
    chk("no_timeout_cyc_cycles", 32'(cyc_cnt), 32'd100);
    chk("no_timeout_err_pulses", 32'(err_cnt), 32'd0);
    wb_if.wb_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("late_ack_ls_ack", {31'd0, ls_ack_o}, 32'd1);
    chk("late_ack_cyc", {31'd0, wb_if.wb_cyc_o}, 32'd0);
    drive(i_idle);
`endif
    @(posedge clk_i);
    #1;
    chk("final_cyc", {31'd0, wb_if.wb_cyc_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
